// File: rtl/b_uart_if.sv
// CPU-side strobe/data bundle of b_uart: the transmit write strobe and the receive read strobe with their data and status.
interface b_uart_if;
  logic       wr;
  logic [7:0] tx_data;
  logic       busy;
  logic       rd;
  logic       valid;
  logic [7:0] rx_data;

  modport master (output wr, output tx_data, input busy,
                  output rd, input valid, input rx_data);
  modport slave  (input wr, input tx_data, output busy,
                  input rd, output valid, output rx_data);
endinterface

// File: rtl/b_uart.sv
// 8N1 UART with a runtime baud rate set by fractional accumulators against CLKFREQ; full-duplex TX/RX.
// Optional macro BUART_FRAMING_CHECK_EN: drop received bytes whose stop-bit sample is 0.
module b_uart #(
  parameter int unsigned CLKFREQ = 1000000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] baud,
  input  logic        rx,
  output logic        tx,
  b_uart_if.slave     cpu
);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Returns {tick, next accumulator}; wraps by CLKFREQ so the long-run rate is exact.
  function automatic logic [32:0] acc_step(input logic [31:0] acc, input logic [32:0] inc);
    logic [33:0] s;
    s = {2'b00, acc} + {1'b0, inc};
    if (s >= 34'(CLKFREQ)) acc_step = {1'b1, 32'(s - 34'(CLKFREQ))};
    else                   acc_step = {1'b0, 32'(s)};
  endfunction

  tx_state_t   tx_state_q;
  logic [31:0] tx_acc_q;
  logic [8:0]  tx_shreg_q;
  logic [3:0]  tx_cnt_q;
  logic        tx_q;
  logic        busy_q;
  logic [32:0] tx_step_d;

  rx_state_t   rx_state_q;
  logic [31:0] rx_acc_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_phase_q;
  logic [2:0]  rx_cnt_q;
  logic [7:0]  rx_shreg_q;
  logic [7:0]  rx_data_q;
  logic        valid_q;
  logic [32:0] rx_step_d;
  logic        rx_fall_d;

  assign tx_step_d = acc_step(tx_acc_q, {1'b0, baud});
  assign rx_step_d = acc_step(rx_acc_q, {baud, 1'b0});
  assign rx_fall_d = rx_prev_q & ~rx_s2_q;

  assign tx          = tx_q;
  assign cpu.busy    = busy_q;
  assign cpu.valid   = valid_q;
  assign cpu.rx_data = rx_data_q;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      tx_acc_q   <= '0;
      tx_shreg_q <= '1;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_acc_q <= tx_step_d[31:0];
      case (tx_state_q)
        TX_IDLE: begin
          if (cpu.wr) begin
            tx_acc_q   <= '0;
            tx_shreg_q <= {1'b1, cpu.tx_data};
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            tx_state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_step_d[32]) begin
            // Tenth tick ends the stop bit; tx is already high from the ninth.
            if (tx_cnt_q == 4'd9) begin
              tx_state_q <= TX_IDLE;
              busy_q     <= 1'b0;
              tx_q       <= 1'b1;
            end else begin
              tx_q       <= tx_shreg_q[0];
              tx_shreg_q <= {1'b1, tx_shreg_q[8:1]};
              tx_cnt_q   <= tx_cnt_q + 4'd1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state_q <= RX_IDLE;
      rx_acc_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_phase_q <= 1'b0;
      rx_cnt_q   <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_acc_q  <= rx_step_d[31:0];
      // A delivery below overrides this clear when both land on the same edge.
      if (cpu.rd) valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall_d) begin
            rx_acc_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_step_d[32]) begin
            if (rx_s2_q) rx_state_q <= RX_IDLE;
            else begin
              rx_state_q <= RX_DATA;
              rx_phase_q <= 1'b0;
              rx_cnt_q   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_step_d[32]) begin
            if (!rx_phase_q) rx_phase_q <= 1'b1;
            else begin
              rx_phase_q <= 1'b0;
              rx_shreg_q <= {rx_s2_q, rx_shreg_q[7:1]};
              rx_cnt_q   <= rx_cnt_q + 3'd1;
              if (rx_cnt_q == 3'd7) rx_state_q <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_step_d[32]) begin
            if (!rx_phase_q) rx_phase_q <= 1'b1;
            else begin
              rx_phase_q <= 1'b0;
              rx_state_q <= RX_IDLE;
`ifdef BUART_FRAMING_CHECK_EN
              if (rx_s2_q) begin
                rx_data_q <= rx_shreg_q;
                valid_q   <= 1'b1;
              end
`else
              rx_data_q <= rx_shreg_q;
              valid_q   <= 1'b1;
`endif
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b_uart.sv
// Self-checking bench for b_uart at 10 cycles/bit: table-driven RX frames, TX frames checked by a tx-line scoreboard.
module tb_b_uart;
  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [31:0] baud = 32'd100000;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [7:0]  tx_sb[$];

  always #5 clk = ~clk;

  b_uart_if cpu();

  b_uart #(.CLKFREQ(1000000)) dut (
    .clk(clk), .resetq(resetq), .baud(baud), .rx(rx), .tx(tx), .cpu(cpu)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         rd_at;
    logic       glitch;
    logic       rd_after;
    logic       exp_valid;
    logic [7:0] exp_data;
  } rx_vec_t;

  rx_vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input int rd_at);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 100; k++) begin
      rx = f[k/10];
      cpu.rd = (k == rd_at);
      @(negedge clk);
    end
    rx = 1'b1;
    cpu.rd = 1'b0;
  endtask

  task automatic run_rx();
    for (int i = 0; i < 6; i++) begin
      if (vec[i].glitch) begin
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("rx_glitch_valid", cpu.valid, 0);
      end
      rx_frame(vec[i].data, vec[i].stop, vec[i].rd_at);
      check($sformatf("rx%0d_valid", i), cpu.valid, vec[i].exp_valid);
      check($sformatf("rx%0d_data", i), cpu.rx_data, vec[i].exp_data);
      if (vec[i].rd_after) begin
        cpu.rd = 1'b1;
        @(negedge clk);
        cpu.rd = 1'b0;
        check($sformatf("rx%0d_rd_valid", i), cpu.valid, 0);
        check($sformatf("rx%0d_rd_data", i), cpu.rx_data, vec[i].exp_data);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic run_tx();
    logic [9:0] f;
    int busy_cycles;
    int bit_ok;
    f = {1'b1, 8'hA5, 1'b0};
    busy_cycles = 0;
    cpu.tx_data = 8'hA5;
    cpu.wr = 1'b1;
    tx_sb.push_back(8'hA5);
    @(negedge clk);
    cpu.wr = 1'b0;
    for (int j = 0; j < 10; j++) begin
      bit_ok = 0;
      for (int c = 0; c < 10; c++) begin
        if (tx === f[j]) bit_ok++;
        if (cpu.busy === 1'b1) busy_cycles++;
        if (j * 10 + c == 50) begin
          cpu.wr = 1'b1;
          cpu.tx_data = 8'hFF;
        end else cpu.wr = 1'b0;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d_cycles", j), bit_ok, 10);
    end
    check("tx_busy_cycles", busy_cycles, 100);
    check("tx_busy_end", cpu.busy, 0);
    check("tx_idle_end", tx, 1);
    repeat (3) @(negedge clk);
    cpu.tx_data = 8'hC3;
    cpu.wr = 1'b1;
    tx_sb.push_back(8'hC3);
    @(negedge clk);
    cpu.wr = 1'b0;
    repeat (110) @(negedge clk);
  endtask

  // TX line monitor: decode each frame at mid-bit and compare against the scoreboard.
  initial begin
    logic       prev;
    logic [7:0] d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetq && prev && !tx) begin
        repeat (4) @(negedge clk);
        check("txmon_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = tx;
        end
        repeat (10) @(negedge clk);
        check("txmon_stop", tx, 1);
        check("txmon_frame_expected", tx_sb.size() > 0, 1);
        if (tx_sb.size() > 0) check("txmon_data", d, tx_sb.pop_front());
      end
      prev = tx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{8'h3C, 1'b1, -1, 1'b0, 1'b1, 1'b1, 8'h3C};
    vec[1] = '{8'h55, 1'b1, -1, 1'b1, 1'b1, 1'b1, 8'h55};
    vec[2] = '{8'h11, 1'b1, -1, 1'b0, 1'b0, 1'b1, 8'h11};
    vec[3] = '{8'h22, 1'b1, -1, 1'b0, 1'b0, 1'b1, 8'h22};
    vec[4] = '{8'h33, 1'b1, 97, 1'b0, 1'b1, 1'b1, 8'h33};
`ifdef BUART_FRAMING_CHECK_EN
    vec[5] = '{8'h7E, 1'b0, -1, 1'b0, 1'b0, 1'b0, 8'h33};
`else
    vec[5] = '{8'h7E, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h7E};
`endif
    cpu.wr = 1'b0;
    cpu.rd = 1'b0;
    cpu.tx_data = 8'h00;
    resetq = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rx = ~rx;
    end
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", cpu.busy, 0);
    check("reset_valid", cpu.valid, 0);
    check("reset_rx_data", cpu.rx_data, 8'h00);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    repeat (3) @(negedge clk);
    fork
      run_tx();
      run_rx();
    join
    repeat (20) @(negedge clk);
    check("tx_sb_empty", tx_sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/b_uart.md
# b_uart

Runtime-programmable-baud 8N1 UART with one transmitter and one receiver sharing a single clock. Sits between a CPU's memory-mapped I/O strobes (`wr`, `rd`) and the board's serial pins. The bit rate is set live from a 32-bit `baud` input against a fixed clock frequency parameter, using fractional accumulators, so there is no fixed divider.

## Interface
Parameters:
- `CLKFREQ`, default 1000000: frequency of `clk` in Hz. Must satisfy `CLKFREQ` > 4·`baud`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetq`  in  1  asynchronous active-low reset.
- `baud`  in  32  bit rate in bits/s. Sampled continuously and may change at any time; a change mid-frame corrupts only that frame.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `tx`  out  1  serial output, idle high.
- `wr`  in  1  one-cycle strobe: transmit `tx_data`.
- `tx_data`  in  8  byte to send, sampled on the `wr` cycle only.
- `busy`  out  1  transmitter occupied.
- `rd`  in  1  one-cycle strobe: consume the received byte and clear `valid`.
- `valid`  out  1  received byte available.
- `rx_data`  out  8  last received byte.

## Operation
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- TX baud generator: a 32-bit accumulator.
  - Each cycle: `s = acc + baud`. If `s >= CLKFREQ`, emit a tick and set `acc = s - CLKFREQ`; otherwise `acc = s`.
  - The accumulator is cleared when a `wr` is accepted.
- TX states IDLE → SHIFT.
  - In IDLE, `wr` loads the 10-bit frame into a shift register, drives `tx = 0` (start bit) and sets `busy`.
  - Each TX tick shifts out the next bit.
  - After the stop bit's tick, return to IDLE and clear `busy`.
  - `wr` while `busy` is ignored; there is no queue.
- RX input passes through a 2-flop synchronizer before any use.
- RX baud generator: same accumulator form, but adds 2·`baud` (half-bit ticks). Cleared on start-edge detection.
- RX states IDLE → START → DATA → STOP.
  - IDLE: a synchronized 1→0 transition enters START.
  - START: at the 1st half-tick (mid start bit), sample. If the sample is 1, treat it as a glitch and return to IDLE. If 0, enter DATA.
  - DATA: sample every 2 half-ticks (mid-bit) into an LSB-first shift register, 8 samples.
  - STOP: sample 2 half-ticks later, then return to IDLE.
- Byte delivery at the STOP sample: load `rx_data` and set `valid`.
- Overrun: a new byte overwrites `rx_data`; `valid` stays 1.
- `rd` clears `valid`. `rd` in the same cycle as a delivery leaves `valid = 1` with the new data, because the delivery wins.
- `rx_data` holds its value after `rd`.

## Timing
- Reset values: `tx = 1`, `busy = 0`, `valid = 0`, `rx_data = 0`. Both accumulators 0, both FSMs IDLE.
- Reset asserted mid-frame aborts at once. `tx` returns high asynchronously.
- After `wr` at edge N, `tx` and `busy` change at edge N+1.
- Each bit lasts floor/ceil(`CLKFREQ`/`baud`) cycles; the long-run average is exact. With an exact ratio R, `busy` stays high exactly 10·R cycles.
- `valid` rises one edge after the stop-bit sample, about 9.5 bit times plus 2–3 cycles (synchronizer) after the `rx` falling edge.
- `rd` clears `valid` at the next edge.
- TX and RX are fully independent; simultaneous operation is required (full duplex).

## Configuration
- `BUART_FRAMING_CHECK_EN` defined: a stop-bit sample of 0 (framing error) discards the byte. `rx_data` and `valid` are unchanged and the RX FSM returns to IDLE.
- Undefined: the byte is delivered regardless of the stop-bit value.

## Test plan
Parameters for all scenarios: `CLKFREQ=1000000`, `baud=100000`, giving 10 cycles/bit.
- Reset: hold `resetq = 0`, toggle `rx` → `tx = 1`, `busy = 0`, `valid = 0`, `rx_data = 0x00`.
- TX 0xA5: pulse `wr` → `tx` reads 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles. `busy` is high for 100 cycles. A second `wr` at cycle 50 has no effect.
- RX 0x3C: drive a frame at 10 cycles/bit → `valid = 1`, `rx_data = 0x3C`. Then pulse `rd` → `valid = 0` next cycle, `rx_data` still 0x3C.
- Glitch: `rx` low for 3 cycles then high → no delivery and `valid` stays 0. A following 0x55 frame is received correctly.
- Overrun / same-cycle `rd`: send 0x11 then 0x22 with no `rd` → `rx_data = 0x22`, `valid = 1`. Pulse `rd` on the delivery cycle of 0x33 → `valid = 1`, `rx_data = 0x33`.
- Framing error: frame 0x7E with stop bit 0 → with `BUART_FRAMING_CHECK_EN` defined, `valid` stays 0. Without it, `rx_data = 0x7E` and `valid = 1`.
